// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring integer divider: one quotient bit per clock, early divide-by-zero/overflow exit.
// Define DIV_SIGNED_EN to compile in two's-complement operands (adds a SIGN fix-up state).
module nonrestoring_divider #(
  parameter int N  = 10,
  parameter int D  = 5,
  parameter int QW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          gotResult,
  input  logic [N-1:0]  dividend,
  input  logic [D-1:0]  divisor,
  output logic [QW-1:0] Q,
  output logic [D-1:0]  R,
  output logic          busy,
  output logic          done,
  output logic          divByZero,
  output logic          ov
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = (N > D) ? N : D;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ITER = 3'd1,
    S_FIX  = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [D:0]       a_q, a_d;
  logic [D:0]       m_q, m_d;
  logic [N-1:0]     qr_q, qr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QW-1:0]    q_out_q, q_out_d;
  logic [D-1:0]     r_out_q, r_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ov_q, ov_d;
`ifdef DIV_SIGNED_EN
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
`endif

  logic [N-1:0] dvd_mag;
  logic [D-1:0] dvs_mag;
  logic [CW-1:0] ov_lhs, ov_rhs;
  logic [D:0]   a_sh, a_step, a_fix;

  // Signed mode works on magnitudes; the overflow test loses one quotient bit to the sign.
`ifdef DIV_SIGNED_EN
  assign dvd_mag = dividend[N-1] ? -dividend : dividend;
  assign dvs_mag = divisor[D-1]  ? -divisor  : divisor;
  assign ov_lhs  = CW'(dvd_mag >> (QW - 1));
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign ov_lhs  = CW'(dvd_mag >> QW);
`endif
  assign ov_rhs  = CW'(dvs_mag);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    qr_d    = qr_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dbz_d   = dbz_q;
    ov_d    = ov_q;
`ifdef DIV_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    // Partial remainder stays within [-M, M); the sign before the shift picks add or subtract.
    a_sh   = {a_q[D-1:0], qr_q[N-1]};
    a_step = a_q[D] ? (a_sh + m_q) : (a_sh - m_q);
    a_fix  = a_q[D] ? (a_q + m_q) : a_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          qr_d    = dvd_mag;
          m_d     = {1'b0, dvs_mag};
          a_d     = '0;
          cnt_d   = '0;
          q_out_d = '0;
          r_out_d = '0;
`ifdef DIV_SIGNED_EN
          neg_q_d = dividend[N-1] ^ divisor[D-1];
          neg_r_d = dividend[N-1];
`endif
          dbz_d = (dvs_mag == '0);
          ov_d  = (dvs_mag != '0) && (ov_lhs >= ov_rhs);
          if ((dvs_mag == '0) || (ov_lhs >= ov_rhs)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        a_d     = a_step;
        qr_d    = qr_q << 1;
        qr_d[0] = ~a_step[D];
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        a_d     = a_fix;
        r_out_d = a_fix[D-1:0];
        q_out_d = qr_q[QW-1:0];
`ifdef DIV_SIGNED_EN
        state_d = S_SIGN;
`else
        state_d = S_DONE;
`endif
      end
`ifdef DIV_SIGNED_EN
      S_SIGN: begin
        if (neg_q_q) q_out_d = -q_out_q;
        if (neg_r_q) r_out_d = -r_out_q;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (gotResult) begin
          state_d = S_IDLE;
          dbz_d   = 1'b0;
          ov_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ITER) || (state_d == S_FIX) || (state_d == S_SIGN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      qr_q    <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      qr_q    <= qr_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ov_q    <= ov_d;
`ifdef DIV_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign Q         = q_out_q;
  assign R         = r_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Bench for nonrestoring_divider: a full-width instance and a QW=5 instance share the same stimulus.
// Expected results come from plain integer division; DIV_SIGNED_EN selects the signed reference.
module tb_nonrestoring_divider;

  localparam int N   = 10;
  localparam int D   = 5;
  localparam int QW  = 10;
  localparam int QW5 = 5;
`ifdef DIV_SIGNED_EN
  localparam int SGN = 1;
`else
  localparam int SGN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic got = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [D-1:0] divisor = '0;

  logic [QW-1:0]  q_a;
  logic [D-1:0]   r_a;
  logic           busy_a, done_a, dbz_a, ov_a;
  logic [QW5-1:0] q_b;
  logic [D-1:0]   r_b;
  logic           busy_b, done_b, dbz_b, ov_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nonrestoring_divider #(.N(N), .D(D), .QW(QW)) dut (
    .clk(clk), .rst(rst), .start(start), .gotResult(got),
    .dividend(dividend), .divisor(divisor),
    .Q(q_a), .R(r_a), .busy(busy_a), .done(done_a), .divByZero(dbz_a), .ov(ov_a)
  );

  nonrestoring_divider #(.N(N), .D(D), .QW(QW5)) dut5 (
    .clk(clk), .rst(rst), .start(start), .gotResult(got),
    .dividend(dividend), .divisor(divisor),
    .Q(q_b), .R(r_b), .busy(busy_b), .done(done_b), .divByZero(dbz_b), .ov(ov_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient truncates toward zero, remainder follows the dividend (SV / and %).
  task automatic model(input logic [N-1:0] dvd, input logic [D-1:0] dvs, input int qw,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dbz, output logic ovf);
    int a, b, qi, ri, mag;
`ifdef DIV_SIGNED_EN
    a = int'($signed(dvd));
    b = int'($signed(dvs));
`else
    a = int'(dvd);
    b = int'(dvs);
`endif
    q = '0; r = '0; dbz = 1'b0; ovf = 1'b0;
    if (b == 0) begin
      dbz = 1'b1;
    end else begin
      qi  = a / b;
      ri  = a % b;
      mag = (qi < 0) ? -qi : qi;
      if (mag >= (1 << (qw - SGN))) begin
        ovf = 1'b1;
      end else begin
        q = qi;
        r = ri;
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "/a_q"}, q_a, 0);
    check({tag, "/a_r"}, r_a, 0);
    check({tag, "/a_busy"}, busy_a, 0);
    check({tag, "/a_done"}, done_a, 0);
    check({tag, "/a_dbz"}, dbz_a, 0);
    check({tag, "/a_ov"}, ov_a, 0);
    check({tag, "/b_done"}, done_b, 0);
    check({tag, "/b_ov"}, ov_b, 0);
    check({tag, "/b_q"}, q_b, 0);
  endtask

  // Ends on the falling edge after the accepting edge.
  task automatic start_op(input logic [N-1:0] dvd, input logic [D-1:0] dvs, input bit hold);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      start    = 1'b0;
      dividend = N'($urandom);
      divisor  = D'($urandom);
    end
  endtask

  // Entered on the falling edge after the accepting edge (edge count 1, counting E0).
  task automatic finish_op(input string tag, input logic [N-1:0] dvd, input logic [D-1:0] dvs);
    logic [31:0] qa, ra, qb, rb;
    logic dza, ova, dzb, ovb;
    logic [QW-1:0] eqa;
    logic [QW5-1:0] eqb;
    logic [D-1:0] era, erb;
    int lat_a, lat_b, nb_a, nb_b;
    model(dvd, dvs, QW, qa, ra, dza, ova);
    model(dvd, dvs, QW5, qb, rb, dzb, ovb);
    eqa = qa[QW-1:0];
    era = ra[D-1:0];
    eqb = qb[QW5-1:0];
    erb = rb[D-1:0];
    lat_a = 0; lat_b = 0; nb_a = 0; nb_b = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy_a) nb_a++;
      if (busy_b) nb_b++;
      if (done_a && lat_a == 0) lat_a = k;
      if (done_b && lat_b == 0) lat_b = k;
      if (lat_a != 0 && lat_b != 0) break;
      @(negedge clk);
    end
    check({tag, "/a_lat"}, lat_a, (dza || ova) ? 1 : N + 2 + SGN);
    check({tag, "/b_lat"}, lat_b, (dzb || ovb) ? 1 : N + 2 + SGN);
    check({tag, "/a_busy_cyc"}, nb_a, (dza || ova) ? 0 : N + 1 + SGN);
    check({tag, "/b_busy_cyc"}, nb_b, (dzb || ovb) ? 0 : N + 1 + SGN);
    repeat (2) @(negedge clk);
    check({tag, "/a_done_held"}, done_a, 1);
    check({tag, "/b_done_held"}, done_b, 1);
    check({tag, "/a_q"}, q_a, eqa);
    check({tag, "/a_r"}, r_a, era);
    check({tag, "/a_dbz"}, dbz_a, dza);
    check({tag, "/a_ov"}, ov_a, ova);
    check({tag, "/b_q"}, q_b, eqb);
    check({tag, "/b_r"}, r_b, erb);
    check({tag, "/b_dbz"}, dbz_b, dzb);
    check({tag, "/b_ov"}, ov_b, ovb);
    got = 1'b1;
    @(posedge clk);
    @(negedge clk);
    got = 1'b0;
    check({tag, "/a_released"}, done_a, 0);
    check({tag, "/b_released"}, done_b, 0);
    check({tag, "/a_flags_clr"}, {dbz_a, ov_a}, 0);
    check({tag, "/b_flags_clr"}, {dbz_b, ov_b}, 0);
    check({tag, "/a_q_kept"}, q_a, eqa);
    $display("[TB] %s dividend=%0d divisor=%0d Q=%0d R=%0d dbz=%0b ov=%0b | QW5: Q=%0d ov=%0b",
             tag, dvd, dvs, q_a, r_a, dbz_a, ov_a, q_b, ov_b);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    // 579/15 with start held: re-accepted on the edge after release.
    start_op(10'd579, 5'd15, 1'b1);
    finish_op("t579", 10'd579, 5'd15);
    @(posedge clk);
    @(negedge clk);
    check("b2b_accept_busy", busy_a, 1);
    start = 1'b0;
    finish_op("t579_b2b", 10'd579, 5'd15);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    start_op(10'd67, 5'd5, 1'b0);
    finish_op("t67_5", 10'd67, 5'd5);

    start_op(10'd67, 5'd0, 1'b0);
    finish_op("t67_0", 10'd67, 5'd0);
    start_op(10'd0, 5'd0, 1'b0);
    finish_op("t0_0", 10'd0, 5'd0);

    // Abort after four iterations; nothing may survive the reset.
    start_op(10'd579, 5'd15, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("midreset");
    start_op(10'd67, 5'd5, 1'b0);
    finish_op("t67_5_after_rst", 10'd67, 5'd5);

    // Negative operands (plain large unsigned values in the default build).
    start_op(10'h3BD, 5'd5, 1'b0);
    finish_op("tneg67_5", 10'h3BD, 5'd5);
    start_op(10'd67, 5'h1B, 1'b0);
    finish_op("t67_neg5", 10'd67, 5'h1B);
    start_op(10'h200, 5'd1, 1'b0);
    finish_op("tmin_1", 10'h200, 5'd1);

    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] rd;
      logic [D-1:0] rs;
      rd = N'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? '0 : D'($urandom);
      start_op(rd, rs, 1'b0);
      finish_op($sformatf("rand%0d", i), rd, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nonrestoring_divider.md
# nonrestoring_divider

Parametrised sequential integer divider: the successor to the fixed 10/5-bit restoring divider. It uses the non-restoring algorithm, with one quotient bit per cycle and a single add/subtract per step. It generalises dividend, divisor and quotient widths, adds early divide-by-zero and overflow detection, and adds an optional two's-complement mode. It sits in the datapath as a multi-cycle slave, controlled by a level `start` / `done` / `gotResult` handshake.

## Interface
- `N`, default 10: dividend width, and the number of iteration cycles.
- `D`, default 5: divisor width, and the remainder width.
- `QW`, default 10: quotient output width, with 1 ≤ QW ≤ N.
- `clk`  in  1: rising-edge clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; level-sampled only in IDLE.
- `gotResult`  in  1: consumer acknowledge; sampled only in DONE.
- `dividend`  in  N: captured on the accepting edge.
- `divisor`  in  D: captured on the accepting edge.
- `Q`  out  QW: quotient.
- `R`  out  D: remainder.
- `busy`  out  1: high in ITER and FIX (and SIGN when signed mode is compiled in).
- `done`  out  1: result valid; held until acknowledged.
- `divByZero`  out  1: divisor was 0; valid with `done`.
- `ov`  out  1: quotient does not fit in QW bits; valid with `done`.

## Operation
States: IDLE, ITER, FIX, [SIGN], DONE.

- **Reset:** `rst`=1 at any edge forces IDLE and clears all registers. All outputs read 0 on the next cycle. This applies mid-operation too: the operation is aborted and leaves no residue.
- **IDLE**, `start`=1 at an edge (the accept edge, E0):
  - Capture operands. Q register ← dividend, M ← {0, divisor} (D+1 bits), A ← 0 (D+1 bits, signed), step counter ← 0.
  - If divisor == 0: go to DONE with `divByZero`=1, Q=0, R=0.
  - Else if (dividend >> QW) ≥ divisor: go to DONE with `ov`=1, Q=0, R=0.
  - `divByZero` has priority over `ov`.
  - Otherwise go to ITER.
- **ITER**, one step per edge, N steps:
  - Shift {A, Q} left by 1.
  - If A was non-negative before the shift, A ← A − M; else A ← A + M.
  - Q[0] ← ~A_new[D].
  - After step N, go to FIX.
- **FIX:** if A is negative, A ← A + M. Latch R ← A[D-1:0] and Q ← Qreg[QW-1:0]. Go to DONE (or SIGN when signed mode is compiled in).
- **DONE:** `done`=1 and outputs hold. `gotResult`=1 at an edge moves to IDLE and clears `done`, `divByZero` and `ov`. Q and R keep their values until the next accept.
- **Back-to-back:** if `start` is still high in IDLE, the next operation is accepted on the following edge.
- **Operand changes:** changes after E0 are ignored.
- **Simultaneous events:** `start` is ignored outside IDLE. `gotResult` is ignored outside DONE. `rst` dominates everything.

## Timing
- **Normal result:** `done` rises after edge E0+N+1 (unsigned), so N+2 edges counting E0. With N=10 that is 12 edges. Signed mode adds one edge.
- **Error result:** `done` rises one edge after E0.
- **Release:** `done` falls on the edge that samples `gotResult`=1. The earliest next accept is the edge after that.
- **Signal timing:** all outputs are registered and change only on `clk` rising edges.
- **`busy`:** low in IDLE and DONE.

## Configuration
- **`DIV_SIGNED_EN` defined:** operands are two's complement.
  - Magnitudes are captured at E0.
  - ov test: |dividend| >> (QW−1) ≥ |divisor|. This is conservative: an exact −2^(QW−1) quotient is flagged as overflow.
  - An extra SIGN state follows FIX. It negates Q if the operand signs differ, and negates R if the dividend is negative.
  - The remainder takes the dividend's sign, and the quotient truncates toward zero.
- **`DIV_SIGNED_EN` undefined:** unsigned only, SIGN state absent, latency as above.

## Test plan
- **Unsigned, defaults:** dividend=579 (10'b1001000011), divisor=15, `start` held, `gotResult` asserted late.
  - Expect Q=38, R=9, ov=0, divByZero=0.
  - `done` after 12 edges, held until `gotResult`.
- **Back-to-back:** after acknowledge, reset, then 67/5.
  - Expect Q=13, R=2.
  - `busy` high exactly N+1 cycles.
- **Divide by zero:** 67/0.
  - `done`=1 and `divByZero`=1 one edge after accept; Q=0, R=0, `busy` never high.
- **Overflow:** QW=5, 579/15 (true quotient 38 ≥ 32).
  - `ov`=1 one edge after accept; Q=0.
  - Also check 0/0: expect `divByZero`=1 and `ov`=0.
- **Reset mid-operation:** pulse `rst` at iteration 5 of 579/15.
  - All outputs 0 next cycle, state IDLE.
  - A fresh 67/5 then returns Q=13, R=2.
- **Signed (`DIV_SIGNED_EN`):**
  - −67/5 → Q=−13, R=−2.
  - 67/−5 → Q=−13, R=2.
  - Latency 13 edges.
